// File: rtl/div_man_div.sv
// Iterative restoring mantissa divider: one quotient bit per clock behind a
// start/valid handshake. Produces a normalized quotient mantissa, an
// under-flag for the exponent stage and a rounding request.
module div_man_div #(
  parameter int unsigned SIZE_DATA = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data_div,
  output logic                 o_under_flag,
  output logic                 o_rounding,
  output logic                 o_div_zero
);

  localparam int unsigned QW = SIZE_DATA + 3;  // quotient: mantissa + G/R/S bits
  localparam int unsigned RW = SIZE_DATA + 1;  // remainder: one guard bit for the shift
  localparam int unsigned CW = $clog2(SIZE_DATA + 3);
  localparam logic [CW-1:0] CntInit = CW'(SIZE_DATA + 2);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [SIZE_DATA-1:0] b_q;
  logic [QW-1:0]        q_q;
  logic [RW-1:0]        rem_q;
  logic [CW-1:0]        cnt_q;

  logic [SIZE_DATA-1:0] data_q;
  logic                 under_q, round_q, dz_q;

  logic                 accept;
  logic                 b_zero;
  logic                 last_iter;
  logic                 rem_ge;
  logic [RW-1:0]        rem_sub;
  logic [QW-1:0]        q_calc;
  logic [RW-1:0]        rem_calc;
  logic [SIZE_DATA-1:0] mant;
  logic                 g_bit, r_bit, s_bit, under;

  assign accept    = (state_q == StIdle) && i_start;
  assign b_zero    = (i_data_b == '0);
  assign last_iter = (cnt_q == '0);

  // One restoring-division step; the remainder stays below 2*b so the shift never overflows.
  always_comb begin
    rem_ge   = (rem_q >= {1'b0, b_q});
    rem_sub  = rem_q - {1'b0, b_q};
    q_calc   = {q_q[QW-2:0], rem_ge};
    rem_calc = rem_ge ? (rem_sub << 1) : (rem_q << 1);
  end

  // Normalize the final quotient and derive guard/round/sticky from the last step's values.
  always_comb begin
    if (q_calc[QW-1]) begin
      mant  = q_calc[QW-1:3];
      g_bit = q_calc[2];
      r_bit = q_calc[1];
      s_bit = q_calc[0] | (|rem_calc);
      under = 1'b0;
    end else begin
      mant  = q_calc[QW-2:2];
      g_bit = q_calc[1];
      r_bit = q_calc[0];
      s_bit = |rem_calc;
      under = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = b_zero ? StDone : StCalc;
      end
      StCalc: begin
        if (last_iter) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_ready = (state_q == StIdle);
    o_valid = (state_q == StDone);
  end

  // Operand latch, iteration datapath and registered result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      under_q <= 1'b0;
      round_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (accept) begin
      b_q     <= i_data_b;
      q_q     <= '0;
      rem_q   <= {1'b0, i_data_a};
      cnt_q   <= CntInit;
      data_q  <= b_zero ? '1 : '0;
      under_q <= 1'b0;
      round_q <= 1'b0;
      dz_q    <= b_zero;
    end else if (state_q == StCalc) begin
      q_q   <= q_calc;
      rem_q <= rem_calc;
      if (!last_iter) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        data_q  <= mant;
        under_q <= under;
        round_q <= (g_bit & r_bit) | (r_bit & s_bit);
      end
    end
  end

  assign o_data_div   = data_q;
  assign o_under_flag = under_q;
  assign o_rounding   = round_q;
  assign o_div_zero   = dz_q;

endmodule

// File: tb/tb_div_man_div.sv
// Directed bench for div_man_div: hand-computed quotient vectors, latency,
// handshake, start-ignore and mid-operation reset scenarios.
module tb_div_man_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] da, db;
  logic        ready, valid;
  logic [23:0] qdiv;
  logic        under, rnd, dz;

  int n_cmp  = 0;
  int n_fail = 0;

  div_man_div #(.SIZE_DATA(24)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_data_a    (da),
    .i_data_b    (db),
    .o_ready     (ready),
    .o_valid     (valid),
    .o_data_div  (qdiv),
    .o_under_flag(under),
    .o_rounding  (rnd),
    .o_div_zero  (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] d;
    logic        u;
    logic        r;
    logic        z;
    int          lat;
  } vec_t;

  // Starts one operation and waits (bounded) for o_valid; no checking here.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, output int lat,
                        output logic [23:0] d1, output logic rdy1,
                        output logic [23:0] d, output logic u, output logic r,
                        output logic z);
    @(negedge clk);
    start = 1'b1;
    da    = a;
    db    = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    d1    = qdiv;
    rdy1  = ready;
    while (!valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    d = qdiv;
    u = under;
    r = rnd;
    z = dz;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    da    = '0;
    db    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: ready=%b valid=%b, required ready=1 valid=0", ready, valid);
    end
    n_cmp++;
    if ({qdiv, under, rnd, dz} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h u=%b r=%b z=%b, required all 0", qdiv, under, rnd, dz);
    end
  endtask

  task automatic test_vectors();
    vec_t        v[7];
    int          lat;
    logic [23:0] d1, d;
    logic        rdy1, u, r, z;
    v[0] = '{24'h800000, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, 28};
    v[1] = '{24'hC00000, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 28};
    v[2] = '{24'h800000, 24'hC00000, 24'hAAAAAA, 1'b1, 1'b0, 1'b0, 28};
    v[3] = '{24'h800000, 24'hFFFFFF, 24'h800000, 1'b1, 1'b0, 1'b0, 28};
    v[4] = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 28};
    v[5] = '{24'h900000, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    v[6] = '{24'h800000, 24'hA00000, 24'hCCCCCC, 1'b1, 1'b1, 1'b0, 28};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, lat, d1, rdy1, d, u, r, z);
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d, required %0d", i, lat, v[i].lat);
      end
      n_cmp++;
      if (d !== v[i].d) begin
        n_fail++;
        $display("FAIL vec%0d_data: got %h, required %h", i, d, v[i].d);
      end
      n_cmp++;
      if ({u, r, z} !== {v[i].u, v[i].r, v[i].z}) begin
        n_fail++;
        $display("FAIL vec%0d_flags: got u/r/z=%b%b%b, required %b%b%b", i, u, r, z,
                 v[i].u, v[i].r, v[i].z);
      end
      n_cmp++;
      if (rdy1 !== 1'b0 || d1 !== (v[i].z ? 24'hFFFFFF : 24'h000000)) begin
        n_fail++;
        $display("FAIL vec%0d_accept: ready=%b data=%h, required ready=0 data=%h", i, rdy1, d1,
                 v[i].z ? 24'hFFFFFF : 24'h000000);
      end
    end
  endtask

  // After o_valid: ready rises next cycle, valid drops, result holds.
  task automatic test_hold();
    int          lat;
    logic [23:0] d1, d;
    logic        rdy1, u, r, z;
    run_op(24'h800000, 24'hA00000, lat, d1, rdy1, d, u, r, z);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ready_in_done: got %b, required 0", ready);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b1 || valid !== 1'b0 || {qdiv, under, rnd, dz} !== {24'hCCCCCC, 3'b110})
      begin
        n_fail++;
        $display("FAIL hold_idle: ready=%b valid=%b data=%h u/r/z=%b%b%b, required 1 0 cccccc 110",
                 ready, valid, qdiv, under, rnd, dz);
      end
    end
  endtask

  // Start held through DONE is ignored there and accepted in the following IDLE cycle.
  task automatic test_back_to_back();
    int          lat;
    int          cyc;
    logic [23:0] d1, d;
    logic        rdy1, u, r, z;
    run_op(24'hC00000, 24'h800000, lat, d1, rdy1, d, u, r, z);
    start = 1'b1;
    da    = 24'h800000;
    db    = 24'hC00000;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle_after_done: ready=%b, required 1", ready);
    end
    @(negedge clk);
    start = 1'b0;
    cyc   = 2;
    while (!valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc !== 29) begin
      n_fail++;
      $display("FAIL b2b_spacing: valid %0d cycles after DONE, required 29", cyc);
    end
    n_cmp++;
    if (qdiv !== 24'hAAAAAA || under !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result: data=%h u=%b, required aaaaaa 1", qdiv, under);
    end
  endtask

  task automatic test_start_ignored();
    int          nv = 0;
    int          lat = 0;
    logic [23:0] d = '0;
    @(negedge clk);
    start = 1'b1;
    da    = 24'h800000;
    db    = 24'h800000;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        start = 1'b1;
        da    = 24'hFFFFFF;
        db    = 24'h800000;
      end
      if (c == 11) start = 1'b0;
      if (valid) begin
        nv++;
        lat = c;
        d   = qdiv;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nv !== 1) begin
      n_fail++;
      $display("FAIL ignore_valid_count: got %0d, required 1", nv);
    end
    n_cmp++;
    if (lat !== 28 || d !== 24'h800000) begin
      n_fail++;
      $display("FAIL ignore_result: lat=%0d data=%h, required 28 800000", lat, d);
    end
  endtask

  task automatic test_reset_mid_calc();
    int          nv = 0;
    int          lat;
    logic [23:0] d1, d;
    logic        rdy1, u, r, z;
    @(negedge clk);
    start = 1'b1;
    da    = 24'hFFFFFF;
    db    = 24'h800000;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || valid !== 1'b0 || {qdiv, under, rnd, dz} !== 27'd0) begin
      n_fail++;
      $display("FAIL midreset_state: ready=%b valid=%b data=%h u/r/z=%b%b%b, required 1 0 0 000",
               ready, valid, qdiv, under, rnd, dz);
    end
    repeat (40) begin
      @(negedge clk);
      if (valid) nv++;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_valid: got %0d valids, required 0", nv);
    end
    run_op(24'h800000, 24'h800000, lat, d1, rdy1, d, u, r, z);
    n_cmp++;
    if (lat !== 28 || d !== 24'h800000 || {u, r, z} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_recover: lat=%0d data=%h u/r/z=%b%b%b, required 28 800000 000",
               lat, d, u, r, z);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_man_div.md
# div_man_div

Iterative mantissa divider for the FPU_DIV path, the inverse of the multiplier's mantissa stage. It takes two normalized SIZE_DATA-bit mantissas with the hidden bit at the MSB and produces a normalized quotient mantissa. It also outputs an under-flag that tells the exponent stage to decrement, and a rounding request. The algorithm is restoring division at one quotient bit per clock, behind a start/valid handshake.

## Interface
- SIZE_DATA, 24, mantissa width including hidden bit.
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  start request; accepted only when o_ready=1.
- i_data_a  input  SIZE_DATA  dividend mantissa; MSB must be 1.
- i_data_b  input  SIZE_DATA  divisor mantissa; MSB must be 1, or all-zero for divide-by-zero.
- o_ready  output  1  high in IDLE.
- o_valid  output  1  one-cycle pulse; result outputs are valid.
- o_data_div  output  SIZE_DATA  normalized quotient mantissa; MSB is 1 unless o_div_zero.
- o_under_flag  output  1  raw quotient was below 1.0 and was shifted left by 1.
- o_rounding  output  1  rounding request.
- o_div_zero  output  1  divisor was zero.

## Operation
- States are IDLE, CALC and DONE.
- **IDLE**, when i_start=1:
  - Latch a and b.
  - Clear the quotient register q, which is SIZE_DATA+3 bits.
  - Load the remainder rem, which is SIZE_DATA+1 bits, with zero-extended a.
  - Load the iteration counter with SIZE_DATA+2.
  - If b==0, go to DONE with dz=1. Otherwise go to CALC.
- i_start is ignored outside IDLE. Operands are sampled only on the accepting edge; later input changes have no effect.
- **CALC**, once per cycle:
  - If rem>=b: shift 1 into the LSB of q and set rem=(rem-b)<<1.
  - Else: shift 0 into q and set rem=rem<<1.
  - Decrement the counter. After the iteration with counter==0, go to DONE.
  - This gives SIZE_DATA+3 iterations.
- Result extraction on the CALC→DONE edge, with outputs registered (N=SIZE_DATA):
  - If q[N+2]=1: o_data_div=q[N+2:3], G=q[2], R=q[1], S=q[0] | (rem!=0), o_under_flag=0.
  - If q[N+2]=0: o_data_div=q[N+1:2], G=q[1], R=q[0], S=(rem!=0), o_under_flag=1.
  - o_rounding=(G&R)|(R&S). This is the same request formula as the multiplier mantissa stage.
- Divide-by-zero result: o_data_div=all ones, o_div_zero=1, o_under_flag=0, o_rounding=0.
- **DONE**: o_valid=1 for exactly this one cycle, then go to IDLE. A start in DONE is ignored.
- Result outputs hold their values from DONE until the next accepted start; they are cleared on that accepting edge.
- A nonzero divisor with MSB=0, or a dividend with MSB=0, is out of contract; the result is unspecified and is not checked.

## Timing
- Reset values:
  - State is IDLE.
  - o_ready=1.
  - o_valid, o_data_div, o_under_flag, o_rounding and o_div_zero are all 0.
  - q, rem and the counter are 0.
- Reset mid-CALC or in DONE aborts immediately: no o_valid, and state returns to IDLE.
- Reset has priority over i_start on the same edge.
- Latency, counted from the edge accepting i_start to o_valid high: SIZE_DATA+4 cycles (28 for 24) for a normal divide, 1 cycle for divide-by-zero.
- o_ready falls the cycle after acceptance and rises the cycle after o_valid.
- Minimum start-to-start spacing is SIZE_DATA+5 cycles (29 for 24), including one IDLE cycle.

## Test plan
- a=0x800000, b=0x800000 → o_valid 28 cycles after start; o_data_div=0x800000, under=0, rounding=0, div_zero=0.
- a=0xC00000, b=0x800000 → 0xC00000, under=0, rounding=0. Then a=0x800000, b=0xC00000 → 0xAAAAAA, under=1 (G=1, R=0, S=1), rounding=0.
- a=0x800000, b=0xFFFFFF → 0x800000, under=1, rounding=0 (G=1, R=0, S=1). Then a=0xFFFFFF, b=0x800000 → 0xFFFFFF, under=0, rounding=0.
- b=0x000000, a=0x900000 → o_valid 1 cycle after start; o_data_div=0xFFFFFF, div_zero=1, rounding=0, under=0.
- Pulse i_start again at cycle 10 of a CALC, with changed operands → ignored; the first result is unchanged and exactly one o_valid is seen.
- Assert i_rst at cycle 15 of a CALC → next cycle IDLE, o_ready=1, all outputs 0, no o_valid. A subsequent a=b=0x800000 then completes correctly.
